pit_programmer: RTL and testbench

Bus master for the mini programmable interval timer's byte-wide config port. On a start pulse it issues the three-write programming sequence (config, reload high, reload low), waits for the timer's counter_set status, then counts timer interrupts until a target count is reached. It sits between on-chip control logic and the timer, replacing manual pin-driven programming.

---
 rtl/pit_pkg.sv | 33 +++
 rtl/pit_irq_counter.sv | 40 ++++
 rtl/pit_programmer.sv | 169 ++++++++++++++++
 tb/tb_pit_programmer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// Shared definitions for the mini PIT config port: register map, config bit
// layout and the programmer's state encoding.
package pit_pkg;

  // Timer register select values on the byte-wide config port
  localparam logic [1:0] ADDR_CFG = 2'b00;
  localparam logic [1:0] ADDR_HI  = 2'b01;
  localparam logic [1:0] ADDR_LO  = 2'b10;

  // Bit positions inside the config register
  localparam int CFG_DIVIDER = 7;
  localparam int CFG_REPEAT  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CFG,
    ST_WR_HI,
    ST_WR_LO,
    ST_WAIT_SET,
    ST_ARMED,
    ST_ERROR
  } pit_state_e;

  // Assemble the config register byte; unused bits are written as zero
  function automatic logic [7:0] cfg_byte(input logic divider_on, input logic repeating);
    logic [7:0] b;
    b = '0;
    b[CFG_DIVIDER] = divider_on;
    b[CFG_REPEAT]  = repeating;
    return b;
  endfunction

endpackage

// File: rtl/pit_irq_counter.sv
// Saturating interrupt counter. hit_o reports, combinationally, whether the
// value the counter takes at the next edge equals the target.
module pit_irq_counter #(
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [IRQ_W-1:0] target_i,
  output logic [IRQ_W-1:0] count_o,
  output logic             hit_o
);

  logic [IRQ_W-1:0] count_q;
  logic [IRQ_W-1:0] count_d;

  // Post-increment value, held at all-ones once saturated
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {IRQ_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
    hit_o = (count_d == target_i);
  end

  // Count register; clear has priority over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pit_programmer.sv
// Bus master that programs the mini PIT (config, reload high, reload low),
// waits for the timer to report counter_set, then counts interrupts up to a
// target. Every output comes straight from a flop.
module pit_programmer
  import pit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int IRQ_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_divider_on,
  input  logic             cfg_repeating,
  input  logic [15:0]      cfg_reload,
  input  logic [IRQ_W-1:0] irq_target,
  output logic             bus_we,
  output logic [1:0]       bus_addr,
  output logic [7:0]       bus_data,
  input  logic             pit_counter_set,
  input  logic             pit_irq,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IRQ_W-1:0] irq_count
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  pit_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      reload_q, reload_d;
  logic [IRQ_W-1:0] target_q, target_d;
  logic             error_q, error_d;
  logic             bus_we_q, bus_we_d;
  logic [1:0]       bus_addr_q, bus_addr_d;
  logic [7:0]       bus_data_q, bus_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_inc, cnt_hit;

  pit_irq_counter #(
    .IRQ_W (IRQ_W)
  ) u_irq_counter (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .target_i (target_q),
    .count_o  (irq_count),
    .hit_o    (cnt_hit)
  );

  // Next state plus the bus/status values that will be visible in that state
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    reload_d   = reload_q;
    target_d   = target_q;
    error_d    = error_q;
    bus_we_d   = 1'b0;
    bus_addr_d = ADDR_CFG;
    bus_data_d = 8'h00;
    done_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            if (pit_counter_set) begin
              // Timer already locked: writes would be ignored
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              reload_d   = cfg_reload;
              target_d   = irq_target;
              error_d    = 1'b0;
              cnt_clr    = 1'b1;
              state_d    = ST_WR_CFG;
              bus_we_d   = 1'b1;
              bus_addr_d = ADDR_CFG;
              bus_data_d = cfg_byte(cfg_divider_on, cfg_repeating);
            end
          end
        end
        ST_WR_CFG: begin
          state_d    = ST_WR_HI;
          bus_we_d   = 1'b1;
          bus_addr_d = ADDR_HI;
          bus_data_d = reload_q[15:8];
        end
        ST_WR_HI: begin
          state_d    = ST_WR_LO;
          bus_we_d   = 1'b1;
          bus_addr_d = ADDR_LO;
          bus_data_d = reload_q[7:0];
        end
        ST_WR_LO: begin
          state_d = ST_WAIT_SET;
          tmo_d   = '0;
        end
        ST_WAIT_SET: begin
          if (pit_counter_set) begin
            state_d = ST_ARMED;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_ARMED: begin
          cnt_inc = pit_irq;
          // A zero target completes immediately, without any interrupt
          if ((target_q == '0) || cnt_hit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      reload_q   <= '0;
      target_q   <= '0;
      error_q    <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= ADDR_CFG;
      bus_data_q <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      reload_q   <= reload_d;
      target_q   <= target_d;
      error_q    <= error_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus_we   = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_data = bus_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_pit_programmer.sv
// Bench for pit_programmer: randomized programming runs against a
// transaction-level expectation of the bus writes, timeout and IRQ counting.
module tb_pit_programmer;

  localparam int TMO = 16;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          reset, start, abort, cfg_divider_on, cfg_repeating;
  logic [15:0]   cfg_reload;
  logic [IW-1:0] irq_target;
  logic          bus_we;
  logic [1:0]    bus_addr;
  logic [7:0]    bus_data;
  logic          pit_counter_set, pit_irq;
  logic          busy, done, error;
  logic [IW-1:0] irq_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pit_programmer #(
    .TIMEOUT_CYCLES (TMO),
    .IRQ_W          (IW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_divider_on  (cfg_divider_on),
    .cfg_repeating   (cfg_repeating),
    .cfg_reload      (cfg_reload),
    .irq_target      (irq_target),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_data        (bus_data),
    .pit_counter_set (pit_counter_set),
    .pit_irq         (pit_irq),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .irq_count       (irq_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change the config inputs; after acceptance this must have no effect
  task automatic scramble();
    cfg_divider_on = 1'($urandom_range(0, 1));
    cfg_repeating  = 1'($urandom_range(0, 1));
    cfg_reload     = 16'($urandom);
    irq_target     = IW'($urandom);
  endtask

  // Full programming run: three writes, counter_set after set_delay WAIT_SET
  // cycles, then random interrupts until the count reaches the target.
  task automatic run_prog(input logic div, input logic rep, input logic [15:0] rel,
                          input logic [IW-1:0] tgt, input int set_delay, input int irq_pct,
                          input int tail);
    logic [1:0] exp_addr [3];
    logic [7:0] exp_data [3];
    int  cnt;
    bit  fin;
    bit  irq;
    exp_addr[0] = 2'b00; exp_data[0] = {div, rep, 6'b000000};
    exp_addr[1] = 2'b01; exp_data[1] = rel[15:8];
    exp_addr[2] = 2'b10; exp_data[2] = rel[7:0];
    cfg_divider_on  = div;
    cfg_repeating   = rep;
    cfg_reload      = rel;
    irq_target      = tgt;
    pit_counter_set = 1'b0;
    start           = 1'b1;
    pit_irq         = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr%0d_we", i), bus_we, 1);
      check($sformatf("wr%0d_addr", i), bus_addr, exp_addr[i]);
      check($sformatf("wr%0d_data", i), bus_data, exp_data[i]);
      check($sformatf("wr%0d_busy", i), busy, 1);
      check($sformatf("wr%0d_err", i), error, 0);
      check($sformatf("wr%0d_cnt", i), irq_count, 0);
      scramble();
      start   = 1'($urandom_range(0, 1));
      pit_irq = 1'($urandom_range(0, 1));
      tick();
    end
    for (int d = 0; d < set_delay; d++) begin
      check("wait_we", bus_we, 0);
      check("wait_data", bus_data, 0);
      check("wait_busy", busy, 1);
      check("wait_cnt", irq_count, 0);
      start   = 1'($urandom_range(0, 1));
      pit_irq = 1'($urandom_range(0, 1));
      tick();
    end
    check("set_busy", busy, 1);
    check("set_err", error, 0);
    pit_counter_set = 1'b1;
    start   = 1'b0;
    pit_irq = 1'($urandom_range(0, 1));
    tick();
    cnt = 0;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      irq = (tgt != 0) && ($urandom_range(1, 100) <= irq_pct);
      pit_irq = irq;
      if (irq && cnt < 255) cnt++;
      tick();
      if (tgt == 0 || cnt == int'(tgt)) begin
        fin = 1'b1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_cnt", irq_count, cnt);
      end else begin
        check("armed_done", done, 0);
        check("armed_busy", busy, 1);
        check("armed_we", bus_we, 0);
        check("armed_cnt", irq_count, cnt);
      end
    end
    if (!fin) check("armed_bound", 0, 1);
    pit_counter_set = 1'b0;
    for (int k = 0; k < tail; k++) begin
      pit_irq = 1'b1;
      tick();
      check("after_done", done, 0);
      check("after_cnt", irq_count, cnt);
      check("after_busy", busy, 0);
    end
    pit_irq = 1'b0;
    $display("run div=%0d rep=%0d reload=%04h target=%0d set_delay=%0d irqs=%0d",
             div, rep, rel, tgt, set_delay, cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_divider_on = 1'b0;
    cfg_repeating = 1'b0; cfg_reload = '0; irq_target = '0;
    pit_counter_set = 1'b0; pit_irq = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_data", bus_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_cnt", irq_count, 0);
    tick();
    $display("reset check done");

    // Directed example run
    run_prog(1'b1, 1'b1, 16'h1234, 8'd3, 2, 50, 2);

    // Random runs, including set arriving in the last allowed WAIT_SET cycle
    for (int r = 0; r < 6; r++) begin
      run_prog(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
               IW'($urandom_range(1, 20)), (r == 0) ? TMO - 1 : $urandom_range(0, 6),
               $urandom_range(20, 90), 1);
    end

    // Zero target and saturating full-scale target with irq held high
    run_prog(1'b0, 1'b1, 16'h00FF, 8'd0, 0, 0, 2);
    run_prog(1'b1, 1'b0, 16'hA55A, 8'd255, 1, 100, 45);

    // Timeout: counter_set never rises
    start = 1'b1; pit_counter_set = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < TMO; k++) begin
      check("tmo_err_low", error, 0);
      check("tmo_busy", busy, 1);
      tick();
    end
    check("tmo_err", error, 1);
    check("tmo_busy_off", busy, 0);
    check("tmo_we", bus_we, 0);
    tick();
    check("tmo_sticky", error, 1);
    $display("timeout run error=%0d", error);
    run_prog(1'b0, 1'b0, 16'hBEEF, 8'd2, 3, 60, 1);

    // Start while the timer is already locked
    pit_counter_set = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("lock_err", error, 1);
    check("lock_we", bus_we, 0);
    check("lock_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lock_err2", error, 1);
    check("lock_we2", bus_we, 0);
    $display("locked start error=%0d", error);
    run_prog(1'b1, 1'b1, 16'h0102, 8'd1, 0, 80, 1);

    // Abort during WR_HI, with a second start held during WR_CFG
    pit_counter_set = 1'b0; start = 1'b1; cfg_reload = 16'h5678;
    tick();
    check("ab_wr0", bus_addr, 0);
    tick();
    start = 1'b0;
    check("ab_wr1_addr", bus_addr, 1);
    check("ab_wr1_data", bus_data, 8'h56);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_we", bus_we, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ab_no_lo", bus_we, 0);
      check("ab_idle", busy, 0);
    end
    $display("abort run busy=%0d", busy);

    // Reset during WR_CFG
    start = 1'b1; cfg_reload = 16'h9ABC;
    tick();
    start = 1'b0;
    check("rw_we", bus_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_we0", bus_we, 0);
    check("rw_data", bus_data, 0);
    check("rw_addr", bus_addr, 0);
    check("rw_busy", busy, 0);
    check("rw_err", error, 0);
    check("rw_cnt", irq_count, 0);
    tick();
    check("rw_noresume", bus_we, 0);
    $display("reset mid-write busy=%0d", busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
